// File: rtl/carfield_periph_apb_responder.sv
// APB3 responder for the host peripheral window: decodes each upstream
// transfer against the fixed peripheral map and replays it on one registered
// downstream port, with zero-wait error responses for holes and a per-access
// stall watchdog.
module carfield_periph_apb_responder #(
  parameter int unsigned NumSub        = 5,
  parameter bit          CanEnable     = 1'b1,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [31:0]           sub_paddr_o,
  output logic [31:0]           sub_pwdata_o,
  output logic [3:0]            sub_pstrb_o,
  output logic                  sub_pwrite_o,
  output logic                  sub_penable_o,
  output logic [NumSub-1:0]     sub_psel_o,
  input  logic [NumSub*32-1:0]  sub_prdata_i,
  input  logic [NumSub-1:0]     sub_pready_i,
  input  logic [NumSub-1:0]     sub_pslverr_i,
  output logic                  timeout_o,
  output logic [15:0]           timeout_cnt_o
);

  localparam int unsigned IdxW = (NumSub > 1) ? $clog2(NumSub) : 1;

  typedef enum logic [1:0] {IDLE, DSETUP, DACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              dec_hit;
  logic [IdxW-1:0]   dec_idx;
  logic [31:0]       sub_rdata [NumSub];

  // Next-cycle values of every output; all outputs are flops.
  logic [31:0]       prdata_d;
  logic              pready_d, pslverr_d;
  logic [31:0]       sub_paddr_d, sub_pwdata_d;
  logic [3:0]        sub_pstrb_d;
  logic              sub_pwrite_d, sub_penable_d;
  logic [NumSub-1:0] sub_psel_d;
  logic              timeout_d;
  logic [15:0]       timeout_cnt_d;

  function automatic logic [NumSub-1:0] onehot(input logic [IdxW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Unpack the flat downstream read-data bus into per-port words.
  always_comb begin
    for (int unsigned k = 0; k < NumSub; k++) begin
      sub_rdata[k] = sub_prdata_i[32*k +: 32];
    end
  end

  // Peripheral map decode on the 4 KiB page number.
  always_comb begin
    dec_hit = 1'b1;
    dec_idx = '0;
    case (paddr_i[31:12])
      20'h20001: begin dec_hit = CanEnable; dec_idx = IdxW'(0); end
      20'h20004: dec_idx = IdxW'(1);
      20'h20005: dec_idx = IdxW'(2);
      20'h20007: dec_idx = IdxW'(3);
      20'h20009: dec_idx = IdxW'(4);
      default:   dec_hit = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so the registered values line up with that state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    prdata_d      = '0;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    sub_paddr_d   = sub_paddr_o;
    sub_pwdata_d  = sub_pwdata_o;
    sub_pstrb_d   = sub_pstrb_o;
    sub_pwrite_d  = sub_pwrite_o;
    sub_penable_d = 1'b0;
    sub_psel_d    = '0;
    timeout_d     = 1'b0;
    timeout_cnt_d = timeout_cnt_o;

    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          sub_paddr_d  = paddr_i;
          sub_pwdata_d = pwdata_i;
          sub_pstrb_d  = pstrb_i;
          sub_pwrite_d = pwrite_i;
          if (dec_hit) begin
            idx_d      = dec_idx;
            cnt_d      = '0;
            sub_psel_d = onehot(dec_idx);
            state_d    = DSETUP;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = RESP;
          end
        end
      end

      DSETUP: begin
        sub_psel_d    = onehot(idx_q);
        sub_penable_d = 1'b1;
        state_d       = DACCESS;
      end

      DACCESS: begin
        if (sub_pready_i[idx_q]) begin
          pready_d  = 1'b1;
          prdata_d  = sub_pwrite_o ? '0 : sub_rdata[idx_q];
          pslverr_d = sub_pslverr_i[idx_q];
          state_d   = RESP;
        end else if ((TimeoutCycles != 0) && (cnt_q == 32'(TimeoutCycles - 1))) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          timeout_d = 1'b1;
          if (timeout_cnt_o != 16'hFFFF) begin
            timeout_cnt_d = timeout_cnt_o + 16'd1;
          end
          state_d   = RESP;
        end else begin
          cnt_d         = cnt_q + 32'd1;
          sub_psel_d    = onehot(idx_q);
          sub_penable_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      prdata_o      <= '0;
      pready_o      <= 1'b0;
      pslverr_o     <= 1'b0;
      sub_paddr_o   <= '0;
      sub_pwdata_o  <= '0;
      sub_pstrb_o   <= '0;
      sub_pwrite_o  <= 1'b0;
      sub_penable_o <= 1'b0;
      sub_psel_o    <= '0;
      timeout_o     <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      prdata_o      <= prdata_d;
      pready_o      <= pready_d;
      pslverr_o     <= pslverr_d;
      sub_paddr_o   <= sub_paddr_d;
      sub_pwdata_o  <= sub_pwdata_d;
      sub_pstrb_o   <= sub_pstrb_d;
      sub_pwrite_o  <= sub_pwrite_d;
      sub_penable_o <= sub_penable_d;
      sub_psel_o    <= sub_psel_d;
      timeout_o     <= timeout_d;
      timeout_cnt_o <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_carfield_periph_apb_responder.sv
// Directed bench for carfield_periph_apb_responder: upstream host driver,
// configurable downstream responder and an expected-response queue.
module tb_carfield_periph_apb_responder;

  localparam int unsigned NumSub = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          paddr, pwdata;
  logic                 psel, penable, pwrite;
  logic [3:0]           pstrb;
  logic [31:0]          prdata;
  logic                 pready, pslverr;
  logic [31:0]          sub_paddr, sub_pwdata;
  logic [3:0]           sub_pstrb;
  logic                 sub_pwrite, sub_penable;
  logic [NumSub-1:0]    sub_psel;
  logic [NumSub*32-1:0] sub_prdata;
  logic [NumSub-1:0]    sub_pready, sub_pslverr;
  logic                 timeout;
  logic [15:0]          timeout_cnt;

  // Second instance with CAN disabled; own psel/penable, shared otherwise.
  logic                 psel_nc, penable_nc;
  logic [31:0]          prdata_nc, sub_paddr_nc, sub_pwdata_nc;
  logic                 pready_nc, pslverr_nc, sub_pwrite_nc, sub_penable_nc;
  logic [3:0]           sub_pstrb_nc;
  logic [NumSub-1:0]    sub_psel_nc;
  logic                 timeout_nc;
  logic [15:0]          timeout_cnt_nc;

  always #5 clk = ~clk;

  carfield_periph_apb_responder #(
    .NumSub(NumSub), .CanEnable(1'b1), .TimeoutCycles(4)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .sub_paddr_o(sub_paddr), .sub_pwdata_o(sub_pwdata),
    .sub_pstrb_o(sub_pstrb), .sub_pwrite_o(sub_pwrite),
    .sub_penable_o(sub_penable), .sub_psel_o(sub_psel),
    .sub_prdata_i(sub_prdata), .sub_pready_i(sub_pready),
    .sub_pslverr_i(sub_pslverr), .timeout_o(timeout),
    .timeout_cnt_o(timeout_cnt)
  );

  carfield_periph_apb_responder #(
    .NumSub(NumSub), .CanEnable(1'b0), .TimeoutCycles(4)
  ) u_nocan (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel_nc),
    .penable_i(penable_nc), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .prdata_o(prdata_nc), .pready_o(pready_nc),
    .pslverr_o(pslverr_nc), .sub_paddr_o(sub_paddr_nc),
    .sub_pwdata_o(sub_pwdata_nc), .sub_pstrb_o(sub_pstrb_nc),
    .sub_pwrite_o(sub_pwrite_nc), .sub_penable_o(sub_penable_nc),
    .sub_psel_o(sub_psel_nc), .sub_prdata_i(sub_prdata),
    .sub_pready_i(sub_pready), .sub_pslverr_i(sub_pslverr),
    .timeout_o(timeout_nc), .timeout_cnt_o(timeout_cnt_nc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Downstream responder configuration: only cfg_port answers as configured.
  int          cfg_port  = 1;
  int          cfg_waits = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  int          to_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Downstream responder: the configured port becomes ready after cfg_waits
  // access-phase cycles; every other port answers ready+error at once.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NumSub; k++) begin
        if (k == cfg_port) begin
          sub_prdata[32*k +: 32] = cfg_rdata;
          sub_pslverr[k]         = cfg_err;
          sub_pready[k]          = 1'b0;
        end else begin
          sub_prdata[32*k +: 32] = 32'hBAD0_0000 | 32'(k);
          sub_pslverr[k]         = 1'b1;
          sub_pready[k]          = 1'b1;
        end
      end
      if (sub_psel[cfg_port] && sub_penable) begin
        sub_pready[cfg_port] = (w == cfg_waits);
        w++;
      end else begin
        w = 0;
      end
    end
  end

  // Count timeout pulses seen on the main instance.
  initial begin
    forever begin
      @(negedge clk);
      if (timeout === 1'b1) to_pulses++;
    end
  end

  // One upstream transfer; port < 0 marks an expected hole. exp_cycle is the
  // cycle (counted from the setup-sampling edge) in which pready_o must show.
  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st, input int port,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_cycle);
    exp_t e;
    exp_t got;
    logic [NumSub-1:0] exp_sel;
    bit done;
    exp_sel = '0;
    if (port >= 0) exp_sel[port] = 1'b1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (n < exp_cycle) begin
        chk({tag, " sel"}, 32'(sub_psel), 32'(exp_sel));
        chk({tag, " penable"}, 32'(sub_penable), 32'(n >= 2));
        if (port >= 0) begin
          chk({tag, " addr"}, sub_paddr, addr);
          chk({tag, " wdata"}, sub_pwdata, wd);
          chk({tag, " strb/wr"}, {27'd0, sub_pwrite, sub_pstrb}, {27'd0, wr, st});
        end
      end else begin
        chk({tag, " sel at resp"}, 32'(sub_psel), 32'd0);
      end
      if (pready === 1'b1) begin
        done = 1'b1;
        chk({tag, " resp cycle"}, 32'(n), 32'(exp_cycle));
        got = sb.pop_front();
        chk({tag, " prdata"}, prdata, got.rdata);
        chk({tag, " pslverr"}, 32'(pslverr), 32'(got.err));
      end
    end
    if (!done) begin
      chk({tag, " pready timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    paddr = '0; pwdata = '0; pstrb = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    psel_nc = 1'b0; penable_nc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst pready", 32'(pready), 32'd0);
    chk("rst prdata/err", {prdata[30:0], pslverr}, 32'd0);
    chk("rst sel/en", 32'({sub_psel, sub_penable}), 32'd0);
    chk("rst timeout", {15'd0, timeout, timeout_cnt}, 32'd0);
    @(posedge clk); #1;

    // Zero-wait read on port 1
    cfg_port = 1; cfg_waits = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_err = 1'b0;
    do_xfer("rd p1", 32'h2000_4010, 1'b0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, 3);

    // Write on port 4 with 3 waits: write returns zero data
    cfg_port = 4; cfg_waits = 3; cfg_rdata = 32'hFFFF_FFFF; cfg_err = 1'b0;
    do_xfer("wr p4", 32'h2000_9004, 1'b1, 32'h1234_5678, 4'hC, 4, 32'h0, 1'b0, 6);

    // Holes
    do_xfer("hole 6000", 32'h2000_6000, 1'b0, 32'h0, 4'hF, -1, 32'h0, 1'b1, 1);
    do_xfer("hole 8FFC", 32'h2000_8FFC, 1'b1, 32'h55AA_55AA, 4'h3, -1, 32'h0, 1'b1, 1);
    do_xfer("hole 3000", 32'h3000_0000, 1'b0, 32'h0, 4'hF, -1, 32'h0, 1'b1, 1);

    // CAN region with CanEnable=0 (separate instance)
    paddr = 32'h2000_1000; pwrite = 1'b0;
    psel_nc = 1'b1; penable_nc = 1'b0;
    @(posedge clk); #1 penable_nc = 1'b1;
    @(negedge clk);
    chk("nocan pready", 32'(pready_nc), 32'd1);
    chk("nocan pslverr", 32'(pslverr_nc), 32'd1);
    chk("nocan prdata", prdata_nc, 32'd0);
    chk("nocan sel", 32'(sub_psel_nc), 32'd0);
    @(posedge clk); #1 psel_nc = 1'b0; penable_nc = 1'b0;
    @(negedge clk);
    chk("nocan sel after", 32'(sub_psel_nc), 32'd0);
    @(posedge clk); #1;

    // Timeout on port 3, then a normal read on port 2
    cfg_port = 3; cfg_waits = 1000; cfg_rdata = 32'h1111_2222; cfg_err = 1'b0;
    to_pulses = 0;
    do_xfer("timeout p3", 32'h2000_7000, 1'b0, 32'h0, 4'hF, 3, 32'h0, 1'b1, 6);
    chk("timeout pulses", 32'(to_pulses), 32'd1);
    chk("timeout cnt", 32'(timeout_cnt), 32'd1);
    cfg_port = 2; cfg_waits = 0; cfg_rdata = 32'hA5A5_5A5A; cfg_err = 1'b0;
    do_xfer("rd p2", 32'h2000_5008, 1'b0, 32'h0, 4'hF, 2, 32'hA5A5_5A5A, 1'b0, 3);
    chk("timeout pulses after", 32'(to_pulses), 32'd1);

    // Port 0 error propagation with one wait
    cfg_port = 0; cfg_waits = 1; cfg_rdata = 32'hCAFE_F00D; cfg_err = 1'b1;
    do_xfer("err p0", 32'h2000_1004, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 1'b1, 4);

    // Reset during the downstream access phase
    cfg_port = 1; cfg_waits = 10; cfg_rdata = 32'hDEAD_BEEF; cfg_err = 1'b0;
    paddr = 32'h2000_4010; pwrite = 1'b0; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("pre-rst access", 32'({sub_psel, sub_penable}), 32'b000101);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("mid rst sel/en", 32'({sub_psel, sub_penable}), 32'd0);
    chk("mid rst resp", {prdata[29:0], pready, pslverr}, 32'd0);
    chk("mid rst timeout", {15'd0, timeout, timeout_cnt}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cfg_waits = 0;
    do_xfer("rd after rst", 32'h2000_4010, 1'b0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, 3);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
